// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//
// N-input registered stream multiplexer with a round-robin arbiter. Producers
// on each channel present beats with valid_i/data_i/last_i. The arbiter picks
// one channel per cycle and the winning beat is captured into a single output
// register stage that feeds one shared consumer.
//
// Handshake (same rule on every input channel and on the output):
//   a beat transfers on a rising clk_i edge when its valid and its ready are
//   both high in the cycle before that edge. A producer holding valid high must
//   keep data/last stable until the transfer happens. ready never depends on
//   the valid of the same interface except through the grant: ready_o[k] is
//   only raised for the channel the arbiter has granted.
//
// Optional feature (macro STREAM_MUX_LOCK_EN):
//   defined   - packet lock. After a granted beat with last=0 the arbiter stays
//               on that channel until the channel's beat with last=1 has been
//               accepted. If the locked channel drops valid mid-packet the
//               output bubbles and no other channel is served.
//   undefined - arbitration runs every beat; packets from different channels
//               may interleave. last_i is still carried through to last_o.
//
// Parameters:
//   WIDTH - data bits per beat
//   N     - number of input channels (1..32)
//   IDXW  - channel index width, derived from N
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_ni   - asynchronous active-low reset
//   valid_i  - per-channel beat valid
//   data_i   - flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   last_i   - per-channel end-of-packet flag
//   ready_o  - per-channel accept (one-hot or zero, low during reset)
//   valid_o  - output beat valid
//   data_o   - output beat data
//   last_o   - output end-of-packet flag
//   sel_o    - channel the current output beat came from
//   ready_i  - consumer accept
//   state_o  - arbiter state for observation (1 = LOCKED, 0 = IDLE)
// -----------------------------------------------------------------------------
module stream_mux_rr #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int IDXW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N-1:0]       valid_i,
   input  logic [N*WIDTH-1:0] data_i,
   input  logic [N-1:0]       last_i,
   output logic [N-1:0]       ready_o,
   output logic               valid_o,
   output logic [WIDTH-1:0]   data_o,
   output logic               last_o,
   output logic [IDXW-1:0]    sel_o,
   input  logic               ready_i,
   output logic               state_o
);

`ifdef STREAM_MUX_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   lock_q, lock_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;

   logic [IDXW-1:0]   grant;
   logic [IDXW-1:0]   cand;
   logic              grant_valid;
   logic [WIDTH-1:0]  grant_data;
   logic              grant_last;
   logic              load_en;
   logic              accept;

   // Channel index arithmetic modulo N; works for N that is not a power of two.
   function automatic logic [IDXW-1:0] idx_add(input logic [IDXW-1:0] base,
                                               input int              off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return IDXW'(s);
   endfunction

   // ---------------------------------------------------------------------------
   // Output register enable: the stage can take a new beat when it is empty or
   // when its current beat leaves this cycle.
   // ---------------------------------------------------------------------------
   assign load_en = !valid_o || ready_i;

   // ---------------------------------------------------------------------------
   // Grant selection. While locked only the locked channel is considered;
   // otherwise the first valid channel at or after the round-robin pointer wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = '0;
      if (state_q == LOCKED) begin
         grant       = lock_q;
         grant_valid = valid_i[lock_q];
      end else begin
         for (int i = 0; i < N; i++) begin
            cand = idx_add(ptr_q, i);
            if (!grant_valid && valid_i[cand]) begin
               grant       = cand;
               grant_valid = 1'b1;
            end
         end
      end
   end

   assign grant_data = data_i[int'(grant) * WIDTH +: WIDTH];
   assign grant_last = last_i[grant];

   // rst_ni is folded in so no channel sees ready while reset is held.
   assign accept = rst_ni && load_en && grant_valid;

   always_comb begin
      ready_o = '0;
      if (accept) ready_o[grant] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Arbiter state machine: next state, lock index and round-robin pointer.
   // The pointer only moves when the beat just accepted leaves the arbiter
   // unlocked, so a locked packet resumes rotation at lock+1.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ptr_d   = ptr_q;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (LockEn && !grant_last) begin
                  state_d = LOCKED;
                  lock_d  = grant;
               end
            end
            LOCKED: begin
               if (grant_last) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (state_d == IDLE) ptr_d = idx_add(grant, 1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         lock_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         ptr_q   <= ptr_d;
      end
   end

   assign state_o = (state_q == LOCKED);

   // ---------------------------------------------------------------------------
   // Output register. On a stall (valid_o && !ready_i) nothing is written, so
   // the beat on the output holds until the consumer takes it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         last_o  <= 1'b0;
         sel_o   <= '0;
      end else if (accept) begin
         valid_o <= 1'b1;
         data_o  <= grant_data;
         last_o  <= grant_last;
         sel_o   <= grant;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(ready_o));

   a_stall_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i) |=>
         (valid_o && $stable(data_o) && $stable(last_o) && $stable(sel_o)));

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//
// Directed bench for stream_mux_rr (WIDTH=8, N=4). Per-channel producer
// queues drive the inputs and honour the valid/ready rule; a reference model
// of the arbiter predicts every output and ready bit each cycle; transferred
// output beats are logged and matched against hand-written expected
// sequences for each scenario.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

   localparam int W    = 8;
   localparam int N    = 4;
   localparam int IDXW = 2;

   // ---------------------------------------------------------------- clock/reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUT signals
   logic [N-1:0]   valid_i = '0;
   logic [N*W-1:0] data_i  = '0;
   logic [N-1:0]   last_i  = '0;
   logic           ready_i = 1'b1;
   logic [N-1:0]   ready_o;
   logic           valid_o;
   logic [W-1:0]   data_o;
   logic           last_o;
   logic [IDXW-1:0] sel_o;
   logic           state_o;

   stream_mux_rr #(.WIDTH(W), .N(N)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (valid_i),
      .data_i  (data_i),
      .last_i  (last_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .last_o  (last_o),
      .sel_o   (sel_o),
      .ready_i (ready_i),
      .state_o (state_o)
   );

   // ---------------------------------------------------------------- bookkeeping
   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic [15:0] exp_q[$];   // expected transferred beats {last, sel, data}
   logic [15:0] got_q[$];   // observed transferred beats

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] beat(input logic l, input int s, input logic [7:0] d);
      return {l, 7'(s), d};
   endfunction

   task automatic check_seq(input string name);
      check({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check(name, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------------------------------------------------------- producers
   logic [8:0] src_q [N][$];   // {last, data}
   logic [N-1:0] take = '0;

   task automatic push(input int ch, input logic l, input logic [7:0] d);
      src_q[ch].push_back({l, d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are sampled mid-cycle, then retired just after the edge.
   initial forever begin
      @(negedge clk);
      take = valid_i & ready_o;
   end

   initial forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < N; k++)
         if (take[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0) begin
            valid_i[k]         = 1'b1;
            data_i[k*W +: W]   = src_q[k][0][7:0];
            last_i[k]          = src_q[k][0][8];
         end else begin
            valid_i[k]         = 1'b0;
            data_i[k*W +: W]   = '0;
            last_i[k]          = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- reference model
   // Output stage contents and arbiter memory, described as: who was served
   // last, and which channel (if any) owns an unfinished packet.
   int         m_ptr    = 0;
   bit         m_locked = 1'b0;
   int         m_lock   = 0;
   logic       e_valid  = 1'b0;
   logic [W-1:0] e_data = '0;
   logic       e_last   = 1'b0;
   int         e_sel    = 0;

   function automatic int mdl_grant(input logic [N-1:0] v);
      if (m_locked) return v[m_lock] ? m_lock : -1;
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         m_ptr    <= 0;
         m_locked <= 1'b0;
         m_lock   <= 0;
         e_valid  <= 1'b0;
         e_data   <= '0;
         e_last   <= 1'b0;
         e_sel    <= 0;
      end else begin
         g = (!e_valid || ready_i) ? mdl_grant(valid_i) : -1;
         if (g >= 0) begin
            e_valid <= 1'b1;
            e_data  <= data_i[g*W +: W];
            e_last  <= last_i[g];
            e_sel   <= g;
`ifdef STREAM_MUX_LOCK_EN
            // A channel keeps ownership until its packet's last beat.
            m_locked <= !last_i[g];
            m_lock   <= g;
            if (last_i[g]) m_ptr <= (g + 1) % N;
`else
            m_ptr <= (g + 1) % N;
`endif
         end else if (ready_i) begin
            e_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin : compare
      int g;
      logic [N-1:0] er;
      if (chk_en) begin
         g  = (rst_n && (!e_valid || ready_i)) ? mdl_grant(valid_i) : -1;
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         check("ready_o", ready_o, er);
         check("valid_o", valid_o, e_valid);
         check("data_o",  data_o,  e_data);
         check("last_o",  last_o,  e_last);
         check("sel_o",   sel_o,   e_sel);
         if (valid_o && ready_i) got_q.push_back(beat(last_o, sel_o, data_o));
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      ready_i = 1'b1;
      #1;
      rst_n  = 1'b0;
      chk_en = 1'b1;

      // Reset with every channel requesting; round-robin beats queued.
      for (int k = 0; k < N; k++) push(k, 1'b1, 8'h10 + 8'(k));
      push(0, 1'b1, 8'h10);
      push(1, 1'b1, 8'h11);
      repeat (3) tick();
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_data_o",  data_o,  8'h00);
      check("rst_sel_o",   sel_o,   2'd0);
      check("rst_last_o",  last_o,  1'b0);
      check("rst_ready_o", ready_o, 4'h0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("first_grant", ready_o, 4'b0001);
      tick();
      check("first_beat_valid", valid_o, 1'b1);
      check("first_beat_data",  data_o,  8'h10);
      check("first_beat_sel",   sel_o,   2'd0);
      repeat (7) tick();
      exp_q = '{beat(1, 0, 8'h10), beat(1, 1, 8'h11), beat(1, 2, 8'h12),
                beat(1, 3, 8'h13), beat(1, 0, 8'h10), beat(1, 1, 8'h11)};
      check_seq("round_robin");

      // Backpressure: pointer now at channel 2.
      for (int k = 0; k < N; k++) push(k, 1'b1, 8'h10 + 8'(k));
      tick();
      ready_i = 1'b0;
      repeat (5) begin
         tick();
         check("stall_valid", valid_o, 1'b1);
         check("stall_data",  data_o,  8'h12);
         check("stall_sel",   sel_o,   2'd2);
         check("stall_ready", ready_o, 4'h0);
      end
      ready_i = 1'b1;
      repeat (6) tick();
      exp_q = '{beat(1, 2, 8'h12), beat(1, 3, 8'h13), beat(1, 0, 8'h10), beat(1, 1, 8'h11)};
      check_seq("backpressure");

      // Sparse traffic with an idle gap; the second search wraps 3 -> 0 -> 1.
      push(2, 1'b1, 8'h12);
      repeat (3) tick();
      check("gap_valid", valid_o, 1'b0);
      push(1, 1'b1, 8'h11);
      repeat (3) tick();
      exp_q = '{beat(1, 2, 8'h12), beat(1, 1, 8'h11)};
      check_seq("sparse");

      // Packet on channel 1 competing with channel 2 (pointer moved to 1 first).
      push(0, 1'b1, 8'h10);
      repeat (3) tick();
      push(1, 1'b0, 8'hA1);
      push(1, 1'b0, 8'hA2);
      push(1, 1'b1, 8'hA3);
      push(2, 1'b1, 8'hB1);
      push(2, 1'b1, 8'hB2);
      repeat (8) tick();
`ifdef STREAM_MUX_LOCK_EN
      exp_q = '{beat(1, 0, 8'h10), beat(0, 1, 8'hA1), beat(0, 1, 8'hA2),
                beat(1, 1, 8'hA3), beat(1, 2, 8'hB1), beat(1, 2, 8'hB2)};
`else
      exp_q = '{beat(1, 0, 8'h10), beat(0, 1, 8'hA1), beat(1, 2, 8'hB1),
                beat(0, 1, 8'hA2), beat(1, 2, 8'hB2), beat(1, 1, 8'hA3)};
`endif
      check_seq("packet");

      // Reset after the second beat of a three-beat packet.
      push(1, 1'b0, 8'hC1);
      push(1, 1'b0, 8'hC2);
      push(1, 1'b1, 8'hC3);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_valid_o", valid_o, 1'b0);
      check("midrst_data_o",  data_o,  8'h00);
      check("midrst_sel_o",   sel_o,   2'd0);
      check("midrst_ready_o", ready_o, 4'h0);
      repeat (2) tick();
      push(0, 1'b1, 8'hD0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_first_grant", ready_o, 4'b0001);
      repeat (5) tick();
      exp_q = '{beat(0, 1, 8'hC1), beat(1, 0, 8'hD0), beat(1, 1, 8'hC3)};
      check_seq("reset_mid_packet");

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-input, registered stream multiplexer with valid/ready handshake on every input and on the output.
- Round-robin arbitration between channels replaces the static select of the earlier 2:1 mux.
- Optional packet lock keeps a multi-beat packet on one channel until its last beat.
- Sits between several producer streams and one shared consumer (e.g. a shared bus or FIFO write port).

Parameters:
- WIDTH, 8, data bits per beat.
- N, 4, number of input channels; legal range 1..32.
- IDXW, (N>1 ? $clog2(N) : 1), width of the channel index; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  N  per-channel beat valid.
- data_i  input  N*WIDTH  flattened channel data; channel k at bits [k*WIDTH +: WIDTH].
- last_i  input  N  per-channel end-of-packet flag.
- ready_o  output  N  per-channel accept; beat k transfers when valid_i[k] && ready_o[k].
- valid_o  output  1  output beat valid.
- data_o  output  WIDTH  output beat data.
- last_o  output  1  output end-of-packet flag.
- sel_o  output  IDXW  channel index the current output beat came from.
- ready_i  input  1  consumer accept; output transfers when valid_o && ready_i.

Behaviour:
- Clock and reset:
  - One clock domain: clk_i.
  - rst_ni is asynchronous, active-low.
- Reset values:
  - valid_o=0, data_o=0, last_o=0, sel_o=0.
  - Round-robin pointer ptr=0; arbiter state IDLE.
  - ready_o is combinational and reads 0 during reset.
- Output register:
  - Single stage: load_en = !valid_o || ready_i.
  - Full throughput: 1 beat/cycle sustained when ready_i=1.
  - Latency: a beat accepted in cycle t appears on valid_o/data_o/last_o/sel_o in cycle t+1.
- Grant logic (combinational):
  - In IDLE: grant = first k with valid_i[k]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - In LOCKED: grant = locked channel only, and only if its valid_i is high.
  - ready_o[k] = load_en && grant_valid && (grant==k). At most one ready_o bit is high.
- On acceptance (load_en && grant_valid):
  - Register data/last from the granted channel; sel_o <= grant; valid_o <= 1.
  - ptr <= (grant+1) mod N.
- When no acceptance occurs but ready_i=1: valid_o <= 0.
- Stall (valid_o && !ready_i):
  - Output holds all values; all ready_o=0.
  - Arbitration may change with valid_i, but no transfer occurs.
- State machine (only active with STREAM_MUX_LOCK_EN):
  - IDLE -> LOCKED on an accepted beat with last=0; lock index = grant.
  - LOCKED -> IDLE on an accepted beat from the locked channel with last=1.
  - While LOCKED, ptr is not updated until the last beat; it is then set to lock+1.
  - Locked channel deasserts valid_i mid-packet: output bubbles. No other channel is served.
- Boundary conditions:
  - No valid input: valid_o drops after the output beat drains.
  - All channels valid continuously: service order ptr, ptr+1, …; each channel gets 1 of every N beats (unlocked).
  - N=1: grant always 0; sel_o always 0.
  - ptr wraps N-1 -> 0.
  - Reset asserted mid-packet: lock cleared, ptr=0, in-flight output beat discarded. No partial recovery.
- Protocol obligations:
  - Producers hold data/last stable while valid_i && !ready_o.
  - The block never drops or duplicates a beat.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- Defined: packet lock active as in the state machine above; last_o passes through last_i.
- Undefined:
  - No LOCKED state; arbitration runs every beat regardless of last_i.
  - last_i is still registered to last_o, but packets from different channels may interleave.

Test Plan:
(WIDTH=8, N=4 unless stated)
- Reset: rst_ni=0 with valid_i=4'hF -> valid_o=0, data_o=0, sel_o=0, ready_o=0. After release, first grant is channel 0.
- Round-robin: all valid_i=1, ready_i=1, channel k data=8'h10+k, last=1 -> output sequence 10,11,12,13,10,… with sel_o 0,1,2,3,0. First beat appears one cycle after release.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1 -> data_o/sel_o constant and ready_o=0. Releasing ready_i resumes with no lost or duplicate beat.
- Sparse: only valid_i[2] then only valid_i[1] -> sel_o 2 then 1; ptr wraps correctly. valid_o=0 in idle gaps.
- Lock (LOCK_EN defined): channel 1 sends 3 beats with last=0,0,1 while channel 2 is valid -> 3 consecutive sel_o=1, then sel_o=2. Undefined: beats alternate 1,2,1,2.
- Reset mid-packet: assert rst_ni=0 after beat 2 of a 3-beat packet -> outputs at reset values. After release, channel 0 is granted first even though channel 1 had been locked.
